mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control FSM that sequences the MIPS datapath (PC, instruction register, register file `RF`, ALU, shared instruction/data memory `DM`) one instruction at a time. It replaces the fixed single-cycle decode and drives every datapath enable and mux select from a registered state. It tolerates variable memory latency through a ready handshake, and counts retired instructions for the testbench.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `Clk`  in  1: single clock; all state updates on rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Opcode`  in  6: `IR[31:26]` from the instruction register.
- `MemReady`  in  1: memory completes the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each: datapath enables and selects.
- `ALUSrcB`  out  2: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `ALUOp`  out  2: 00 = add, 01 = sub, 10 = funct-decoded.
- `PCSource`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IllegalOp`  out  1: one-cycle pulse on an unsupported opcode.
- `InstrRetired`  out  `CNT_W`: count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDIWB, BRANCH, JUMP. Binary encoded, 4 bits.
- Any output not listed for a state is 0.
- FETCH:
  - Asserts `MemRead`, `ALUSrcB`=01.
  - `IRWrite`=`PCWrite`=`MemReady`. This is the only Mealy term.
  - Holds until `MemReady`, then goes to DECODE.
- DECODE:
  - Asserts `ALUSrcB`=11.
  - Dispatch: 0x00 → EXEC; 0x23/0x2B/0x08 → MEMADDR; 0x04 → BRANCH; 0x02 → JUMP.
  - Any other opcode asserts `IllegalOp` and returns to FETCH.
- MEMADDR: `ALUSrcA`=1, `ALUSrcB`=10. Next state: lw → MEMRD, sw → MEMWR, addi → ADDIWB.
- MEMRD: `IorD`, `MemRead`. Holds until `MemReady`, then MEMWB.
- MEMWB: `MemtoReg`, `RegWrite` (`RegDst`=0). Then FETCH.
- MEMWR: `IorD`, `MemWrite`. Holds until `MemReady`, then FETCH.
- EXEC: `ALUSrcA`=1, `ALUOp`=10. Then RWB.
- RWB: `RegDst`, `RegWrite`. Then FETCH.
- ADDIWB: `RegWrite` (`RegDst`=0, `MemtoReg`=0). Then FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=01, `PCWriteCond`, `PCSource`=01. Then FETCH.
- JUMP: `PCWrite`, `PCSource`=10. Then FETCH.
- `Opcode` is sampled only in DECODE and MEMADDR. The IR is stable there because `IRWrite` is 0.
- `InstrRetired` increments by 1 in these cycles:
  - each cycle in MEMWB, RWB, ADDIWB, BRANCH or JUMP;
  - MEMWR when `MemReady`=1.
- `InstrRetired` wraps modulo 2^`CNT_W`. Illegal opcodes do not count.

## Timing
- Reset:
  - While `Reset`=1, all control outputs and `IllegalOp` are forced to 0 combinationally.
  - On the edge, state ← FETCH and `InstrRetired` ← 0.
  - In the first cycle after release the block is in FETCH with `MemRead`=1.
- Reset mid-operation (e.g. MEMWR waiting): `MemWrite` drops in the same cycle `Reset` rises. The access is abandoned with no retire.
- Latency with `MemReady` tied high:
  - R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds exactly 1.
- `MemReady` outside FETCH/MEMRD/MEMWR is ignored.
- Memory request signals stay constant while waiting. `MemRead`/`MemWrite` are never both 1.
- `IllegalOp` is high for exactly the DECODE cycle. The next cycle is FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_ADDI`, `OP_BEQ`, `OP_J`;
  - `ALUOp`, `ALUSrcB` and `PCSource` codes.
- Sub-module `mips_ctrl_outdec`: purely combinational, maps state to the control word plus the `MemReady` gating and `Reset` forcing. The top holds only the state register, next-state logic and counter.

## Test plan
- Reset held 3 cycles, then released with `Opcode`=0x00, `MemReady`=1:
  - all outputs 0 during reset;
  - state sequence FETCH, DECODE, EXEC, RWB, FETCH;
  - `RegWrite`=`RegDst`=1 only in RWB;
  - `InstrRetired`=1.
- lw with `MemReady` low for 2 cycles in MEMRD:
  - 7 cycles total;
  - `IorD`=`MemRead`=1 held through the waits;
  - `MemtoReg`/`RegWrite` for one cycle.
- Program sequence sw, beq, j, addi with zero wait:
  - cycle counts 4, 3, 3, 4;
  - `PCWriteCond`=1 only in BRANCH;
  - `PCSource`=10 in JUMP;
  - `InstrRetired`=4 after 14 cycles.
- `Opcode`=0x3F:
  - `IllegalOp` high for exactly 1 cycle;
  - return to FETCH;
  - counter unchanged.
- `Reset` asserted while in MEMWR with `MemReady`=0:
  - `MemWrite`=0 in the same cycle;
  - FETCH after the edge;
  - `InstrRetired`=0.
- Counter wrap: preload `CNT_W`=4 and run 17 R-type instructions → `InstrRetired`=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle controller.
// State enum, opcode constants, and datapath select codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_ADDIWB  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder for the multicycle controller.
// Maps state to datapath controls; reset forces everything low.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t i_state,
   input  logic   i_mem_ready,
   input  logic   i_illegal,
   input  logic   i_reset,
   output ctrl_t  o_ctrl
);

   ctrl_t w_c;

   always_comb begin
      w_c = '0;
      unique case (i_state)
         S_FETCH: begin
            w_c.mem_read  = 1'b1;
            w_c.alu_src_b = SRCB_FOUR;
            // Only Mealy term: latch IR and bump PC as memory returns
            w_c.ir_write  = i_mem_ready;
            w_c.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            w_c.alu_src_b  = SRCB_IMM4;
            w_c.illegal_op = i_illegal;
         end
         S_MEMADDR: begin
            w_c.alu_src_a = 1'b1;
            w_c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            w_c.iord     = 1'b1;
            w_c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            w_c.mem_to_reg = 1'b1;
            w_c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            w_c.iord      = 1'b1;
            w_c.mem_write = 1'b1;
         end
         S_EXEC: begin
            w_c.alu_src_a = 1'b1;
            w_c.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            w_c.reg_dst   = 1'b1;
            w_c.reg_write = 1'b1;
         end
         S_ADDIWB: begin
            w_c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_c.alu_src_a     = 1'b1;
            w_c.alu_op        = ALUOP_SUB;
            w_c.pc_write_cond = 1'b1;
            w_c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            w_c.pc_write  = 1'b1;
            w_c.pc_source = PCSRC_JUMP;
         end
         default: w_c = '0;
      endcase
      if (i_reset)
         w_c = '0;
   end

   assign o_ctrl = w_c;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// MIPS multicycle control FSM: state register, dispatch and
// retired-instruction counter; outputs come from mips_ctrl_outdec.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [5:0]       Opcode,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             IllegalOp,
   output logic [CNT_W-1:0] InstrRetired
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_illegal;
   logic             w_retire;
   ctrl_t            w_ctrl;

   always_ff @(posedge Clk) begin
      if (Reset)
         r_state <= S_FETCH;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      unique case (r_state)
         S_FETCH:
            if (MemReady) w_next = S_DECODE;
         S_DECODE: begin
            unique case (Opcode)
               OP_RTYPE: w_next = S_EXEC;
               OP_LW,
               OP_SW,
               OP_ADDI:  w_next = S_MEMADDR;
               OP_BEQ:   w_next = S_BRANCH;
               OP_J:     w_next = S_JUMP;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            unique case (Opcode)
               OP_LW:   w_next = S_MEMRD;
               OP_SW:   w_next = S_MEMWR;
               OP_ADDI: w_next = S_ADDIWB;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMRD:
            if (MemReady) w_next = S_MEMWB;
         S_MEMWR:
            if (MemReady) w_next = S_FETCH;
         S_EXEC:   w_next = S_RWB;
         S_MEMWB,
         S_RWB,
         S_ADDIWB,
         S_BRANCH,
         S_JUMP:   w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   // A store retires only on the cycle memory accepts it
   always_comb begin
      w_retire = 1'b0;
      unique case (r_state)
         S_MEMWB,
         S_RWB,
         S_ADDIWB,
         S_BRANCH,
         S_JUMP:  w_retire = 1'b1;
         S_MEMWR: w_retire = MemReady;
         default: w_retire = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         r_cnt <= '0;
      else if (w_retire)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   mips_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_mem_ready (MemReady),
      .i_illegal   (w_illegal),
      .i_reset     (Reset),
      .o_ctrl      (w_ctrl)
   );

   assign PCWrite      = w_ctrl.pc_write;
   assign PCWriteCond  = w_ctrl.pc_write_cond;
   assign IorD         = w_ctrl.iord;
   assign MemRead      = w_ctrl.mem_read;
   assign MemWrite     = w_ctrl.mem_write;
   assign MemtoReg     = w_ctrl.mem_to_reg;
   assign IRWrite      = w_ctrl.ir_write;
   assign RegDst       = w_ctrl.reg_dst;
   assign RegWrite     = w_ctrl.reg_write;
   assign ALUSrcA      = w_ctrl.alu_src_a;
   assign ALUSrcB      = w_ctrl.alu_src_b;
   assign ALUOp        = w_ctrl.alu_op;
   assign PCSource     = w_ctrl.pc_source;
   assign IllegalOp    = w_ctrl.illegal_op;
   assign InstrRetired = r_cnt;

endmodule
